// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Purpose  : Feeds a DSP48A1 slice (A/B/OPMODE) to form a dot product per
//             vector and returns sum, sticky overflow and element count.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_mac_sequencer #(
   parameter int LAT   = 3,
   parameter int OPDLY = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [17:0] in_a,
   input  logic [17:0] in_b,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [47:0] out_data,
   output logic        out_ovf,
   output logic [15:0] out_count,
   output logic [17:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic [7:0]  dsp_opmode,
   input  logic [47:0] dsp_p,
   input  logic        dsp_carryout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [7:0]  c_OP_FIRST = 8'h01;
   localparam logic [7:0]  c_OP_ACC   = 8'h09;
   localparam logic [7:0]  c_OP_NONE  = 8'h00;
   localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

   state_t      r_state;
   logic [7:0]  r_op_sr [0:OPDLY];
   logic [LAT:0] r_tag_v;
   logic [LAT:0] r_tag_f;
   logic [LAT:0] r_tag_l;
   logic [47:0] r_smp_p;
   logic        r_smp_co;
   logic        r_smp_v;
   logic        r_smp_f;
   logic        r_smp_l;
   logic        r_ovf;
   logic [15:0] r_cnt;

   logic        w_accept;
   logic        w_first;
   logic        w_ovf_upd;
   logic [7:0]  w_op;

   assign w_accept   = in_valid && in_ready;
   assign w_first    = (r_state == S_IDLE);
   assign w_ovf_upd  = r_smp_f ? r_smp_co : (r_ovf | r_smp_co);
   assign dsp_opmode = r_op_sr[OPDLY];

   // Bubbles inside a vector keep Z=P so the running sum survives gaps.
   always_comb begin
      w_op = c_OP_NONE;
      if (w_accept)
         w_op = w_first ? c_OP_FIRST : c_OP_ACC;
      else if (r_state == S_ACC || r_state == S_WAIT)
         w_op = c_OP_ACC;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         out_count <= '0;
         dsp_a     <= '0;
         dsp_b     <= '0;
         for (int i = 0; i <= OPDLY; i++)
            r_op_sr[i] <= '0;
         r_tag_v   <= '0;
         r_tag_f   <= '0;
         r_tag_l   <= '0;
         r_smp_p   <= '0;
         r_smp_co  <= 1'b0;
         r_smp_v   <= 1'b0;
         r_smp_f   <= 1'b0;
         r_smp_l   <= 1'b0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         dsp_a      <= w_accept ? in_a : 18'd0;
         dsp_b      <= w_accept ? in_b : 18'd0;
         r_op_sr[0] <= w_op;
         for (int i = 1; i <= OPDLY; i++)
            r_op_sr[i] <= r_op_sr[i-1];

         r_tag_v <= {r_tag_v[LAT-1:0], w_accept};
         r_tag_f <= {r_tag_f[LAT-1:0], w_accept && w_first};
         r_tag_l <= {r_tag_l[LAT-1:0], w_accept && in_last};

         // Slice outputs are registered together with their emerging tag.
         r_smp_p  <= dsp_p;
         r_smp_co <= dsp_carryout;
         r_smp_v  <= r_tag_v[LAT];
         r_smp_f  <= r_tag_f[LAT];
         r_smp_l  <= r_tag_l[LAT];

         if (r_smp_v)
            r_ovf <= w_ovf_upd;

         if (w_accept) begin
            if (w_first)
               r_cnt <= 16'd1;
            else if (r_cnt != c_CNT_MAX)
               r_cnt <= r_cnt + 16'd1;
         end

         case (r_state)
            S_IDLE: begin
               in_ready <= !(w_accept && in_last);
               if (w_accept)
                  r_state <= in_last ? S_WAIT : S_ACC;
            end
            S_ACC: begin
               in_ready <= !(w_accept && in_last);
               if (w_accept && in_last)
                  r_state <= S_WAIT;
            end
            S_WAIT: begin
               in_ready <= 1'b0;
               if (r_smp_v && r_smp_l) begin
                  r_state   <= S_HOLD;
                  out_valid <= 1'b1;
                  out_data  <= r_smp_p;
                  out_ovf   <= w_ovf_upd;
                  out_count <= r_cnt;
               end
            end
            default: begin
               if (out_ready) begin
                  r_state   <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_sequencer
//  Purpose  : Self-checking bench with a DSP48A1 behavioural slice model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_sequencer;

   localparam int LAT   = 3;
   localparam int OPDLY = 1;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_a = '0;
   logic [17:0] in_b = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [47:0] out_data;
   logic        out_ovf;
   logic [15:0] out_count;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [7:0]  dsp_opmode;
   logic [47:0] dsp_p;
   logic        dsp_carryout;

   dsp_mac_sequencer #(.LAT(LAT), .OPDLY(OPDLY)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .out_count(out_count),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
   );

   always #5 CLK = ~CLK;

   // DSP48A1 slice: A1/B1 regs, M reg, OPMODE reg, P/CARRYOUT regs.
   logic [17:0] m_a1 = '0;
   logic [17:0] m_b1 = '0;
   logic [35:0] m_m = '0;
   logic [7:0]  m_op = '0;
   logic [47:0] m_p = '0;
   logic        m_co = 1'b0;
   logic [48:0] m_sum;
   always_comb
      m_sum = {1'b0, (m_op[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0}
            + {1'b0, (m_op[3:2] == 2'b10) ? m_p : 48'd0};
   always @(posedge CLK) begin
      m_a1 <= dsp_a;
      m_b1 <= dsp_b;
      m_m  <= m_a1 * m_b1;
      m_op <= dsp_opmode;
      {m_co, m_p} <= m_sum;
   end
   assign dsp_p        = m_p;
   assign dsp_carryout = m_co;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   typedef struct packed {
      logic [31:0]      n;
      logic [2:0][17:0] a;
      logic [2:0][17:0] b;
      logic [47:0]      exp_data;
      logic             exp_ovf;
      logic [15:0]      exp_cnt;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [17:0] a0, b0, a1, b1, a2, b2,
                               input logic [47:0] ed, input logic eo, input logic [15:0] ec);
      vec_t v;
      v.n = n;
      v.a[0] = a0; v.b[0] = b0;
      v.a[1] = a1; v.b[1] = b1;
      v.a[2] = a2; v.b[2] = b2;
      v.exp_data = ed; v.exp_ovf = eo; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic push(input logic [17:0] a, input logic [17:0] b, input logic last,
                       input logic first, input bit chk, output int t_acc);
      int w = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      while (!in_ready && w < 200) begin
         @(posedge CLK); #1; w++;
      end
      if (!in_ready) timeout("accept");
      @(posedge CLK); #1;
      t_acc = cyc;
      in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
      if (chk) begin
         check("dsp_a", dsp_a, a);
         check("dsp_b", dsp_b, b);
         repeat (OPDLY) begin @(posedge CLK); #1; end
         check("dsp_opmode", dsp_opmode, first ? 8'h01 : 8'h09);
      end
   endtask

   task automatic get_result(input int t_last, input logic [47:0] ed, input logic eo,
                             input logic [15:0] ec, input int hold);
      int w = 0;
      out_ready = 1'b0;
      while (!out_valid && w < 200) begin
         @(posedge CLK); #1; w++;
      end
      if (!out_valid) timeout("out_valid");
      else begin
         check("latency", cyc - t_last, LAT + 2);
         check("out_data", out_data, ed);
         check("out_ovf", out_ovf, eo);
         check("out_count", out_count, ec);
         repeat (hold) begin
            @(posedge CLK); #1;
            check("hold_valid_data_ready", {out_valid, out_data, in_ready}, {1'b1, ed, 1'b0});
         end
         out_ready = 1'b1;
         @(posedge CLK); #1;
         out_ready = 1'b0;
         check("valid_drop", out_valid, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t tbl [5];
   int   t;
   logic seen;

   initial begin
      tbl[0] = mk(3, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 48'd68, 1'b0, 16'd3);
      tbl[1] = mk(1, 18'h3FFFF, 18'h3FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 48'hFFFF80001, 1'b0, 16'd1);
      tbl[2] = mk(1, 18'd3, 18'd3, 18'd0, 18'd0, 18'd0, 18'd0, 48'd9, 1'b0, 16'd1);
      tbl[3] = mk(2, 18'd5, 18'd5, 18'd1, 18'd2, 18'd0, 18'd0, 48'd27, 1'b0, 16'd2);
      tbl[4] = mk(2, 18'd100, 18'd200, 18'd0, 18'd0, 18'd0, 18'd0, 48'd20000, 1'b0, 16'd2);

      repeat (2) @(posedge CLK);
      #1;
      check("reset_outputs", {in_ready, out_valid, out_data, out_ovf, out_count, dsp_a, dsp_b, dsp_opmode}, '0);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("ready_after_reset", in_ready, 1'b1);

      // Table vectors, run back-to-back (2 then 3 checks no carry-over).
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < int'(tbl[k].n); i++)
            push(tbl[k].a[i], tbl[k].b[i], i == int'(tbl[k].n) - 1, i == 0, 1'b1, t);
         get_result(t, tbl[k].exp_data, tbl[k].exp_ovf, tbl[k].exp_cnt, 0);
      end

      // 4097 maximal products: sum wraps past 2^48.
      for (int i = 0; i < 4097; i++)
         push(18'h3FFFF, 18'h3FFFF, i == 4096, i == 0, 1'b0, t);
      get_result(t, 48'h000F7FF81001, 1'b1, 16'd4097, 0);

      // Bubbles inside a vector, then back-pressure for 5 cycles.
      push(18'd1, 18'd1, 1'b0, 1'b1, 1'b1, t);
      repeat (4) @(posedge CLK);
      #1;
      push(18'd1, 18'd1, 1'b1, 1'b0, 1'b1, t);
      get_result(t, 48'd2, 1'b0, 16'd2, 5);

      // Reset in ACC aborts the vector.
      push(18'd1, 18'd1, 1'b0, 1'b1, 1'b1, t);
      push(18'd2, 18'd2, 1'b0, 1'b0, 1'b1, t);
      #2 RST_N = 1'b0;
      #1;
      check("mid_reset_outputs", {in_ready, out_valid, out_data, out_ovf, out_count, dsp_a, dsp_b, dsp_opmode}, '0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      seen = 1'b0;
      repeat (LAT + 4) begin
         @(posedge CLK); #1;
         seen = seen | out_valid;
      end
      check("no_stale_result", seen, 1'b0);
      push(18'd7, 18'd8, 1'b1, 1'b1, 1'b1, t);
      get_result(t, 48'd56, 1'b0, 16'd1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
